// File: rtl/mrv1_pkg.sv
// Shared types for the mrv1 core blocks: hardware-thread lifecycle state.
package mrv1_pkg;

  typedef enum logic [1:0] {
    TH_IDLE    = 2'd0,
    TH_ACTIVE  = 2'd1,
    TH_STALLED = 2'd2
  } mrv_th_state_e;

endpackage

// File: rtl/mrv1_rr_arb.sv
// Combinational round-robin picker: first requester at or after ptr_i wins.
module mrv1_rr_arb #(
  parameter  int N_P   = 4,
  localparam int PTR_W = $clog2(N_P)
) (
  input  logic [N_P-1:0]   req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N_P-1:0]   gnt_o,
  output logic             vld_o
);

  logic             found;
  logic [PTR_W-1:0] idx;

  // N_P is a power of two, so pointer arithmetic wraps for free.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N_P; i++) begin
      idx = ptr_i + PTR_W'(i);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign vld_o = |req_i;

endmodule

// File: rtl/mrv1_th_sched.sv
// Hardware-thread scheduler: spawn/terminate/stall bookkeeping and round-robin fetch select.
// Define MRV1_TH_SCHED_STATS_EN to add saturating spawn-ack / spawn-fail counters.
module mrv1_th_sched
  import mrv1_pkg::*;
#(
  parameter  int                NUM_THREADS_P = 4,
  parameter  int                PC_WIDTH_P    = 32,
  parameter  logic [PC_WIDTH_P-1:0] RESET_PC_P = '0,
  localparam int                TID_WIDTH_LP  = $clog2(NUM_THREADS_P)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    th_ctl_vld_i,
  input  logic [TID_WIDTH_LP-1:0] th_ctl_tid_i,
  input  logic                    th_ctl_tspawn_vld_i,
  input  logic [PC_WIDTH_P-1:0]   th_ctl_tspawn_pc_i,
  output logic                    th_ctl_spawn_ack_o,
  output logic                    th_ctl_spawn_fail_o,
  output logic [TID_WIDTH_LP-1:0] th_ctl_spawn_tid_o,
  input  logic                    stall_set_vld_i,
  input  logic [TID_WIDTH_LP-1:0] stall_set_tid_i,
  input  logic                    stall_clr_vld_i,
  input  logic [TID_WIDTH_LP-1:0] stall_clr_tid_i,
  input  logic                    fetch_rdy_i,
  output logic                    fetch_vld_o,
  output logic [TID_WIDTH_LP-1:0] fetch_tid_o,
  output logic                    fetch_redirect_o,
  output logic [PC_WIDTH_P-1:0]   fetch_pc_o,
  output logic [NUM_THREADS_P-1:0] active_mask_o,
`ifdef MRV1_TH_SCHED_STATS_EN
  output logic [31:0]             stat_spawn_cnt_o,
  output logic [31:0]             stat_fail_cnt_o,
`endif
  output logic                    halted_o
);

  localparam int N  = NUM_THREADS_P;
  localparam int TW = TID_WIDTH_LP;

  mrv_th_state_e         state_q [N];
  mrv_th_state_e         state_d [N];
  logic [N-1:0]          pend_q, pend_d;
  logic [PC_WIDTH_P-1:0] pc_q [N];
  logic [PC_WIDTH_P-1:0] pc_d [N];
  logic [TW-1:0]         rr_q, rr_d;
  logic                  ack_q, ack_d, fail_q, fail_d;
  logic [TW-1:0]         spawn_tid_q, spawn_tid_d;

  logic [N-1:0]  req, gnt;
  logic          gnt_vld, fire;
  logic [TW-1:0] gnt_tid;
  logic          idle_any;
  logic [TW-1:0] idle_tid;
  logic          spawn_req, term_req;

  always_comb begin
    req           = '0;
    active_mask_o = '0;
    for (int t = 0; t < N; t++) begin
      req[t]           = (state_q[t] == TH_ACTIVE);
      active_mask_o[t] = (state_q[t] != TH_IDLE);
    end
  end

  mrv1_rr_arb #(.N_P(N)) u_arb (
    .req_i (req),
    .ptr_i (rr_q),
    .gnt_o (gnt),
    .vld_o (gnt_vld)
  );

  always_comb begin
    gnt_tid = '0;
    for (int t = 0; t < N; t++)
      if (gnt[t]) gnt_tid = TW'(t);
  end

  // Spawn looks only at registered state, so a thread freed this cycle is not yet visible.
  always_comb begin
    idle_any = 1'b0;
    idle_tid = '0;
    for (int t = N-1; t >= 0; t--) begin
      if (state_q[t] == TH_IDLE) begin
        idle_any = 1'b1;
        idle_tid = TW'(t);
      end
    end
  end

  assign fire      = gnt_vld & fetch_rdy_i;
  assign spawn_req = th_ctl_vld_i & th_ctl_tspawn_vld_i;
  assign term_req  = th_ctl_vld_i & ~th_ctl_tspawn_vld_i;

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    pc_d        = pc_q;
    rr_d        = rr_q;
    ack_d       = 1'b0;
    fail_d      = 1'b0;
    spawn_tid_d = spawn_tid_q;

    if (fire) begin
      rr_d          = gnt_tid + TW'(1);
      pend_d[gnt_tid] = 1'b0;
    end

    for (int t = 0; t < N; t++) begin
      logic s_set, s_clr;
      s_set = stall_set_vld_i && (stall_set_tid_i == TW'(t));
      s_clr = stall_clr_vld_i && (stall_clr_tid_i == TW'(t));
      case (state_q[t])
        TH_ACTIVE:  if (s_set && !s_clr) state_d[t] = TH_STALLED;
        TH_STALLED: if (s_clr && !s_set) state_d[t] = TH_ACTIVE;
        default: ;
      endcase
    end

    // Applied after stall handling so terminate wins on the same thread.
    if (term_req && state_q[th_ctl_tid_i] != TH_IDLE) begin
      state_d[th_ctl_tid_i] = TH_IDLE;
      pend_d[th_ctl_tid_i]  = 1'b0;
    end

    if (spawn_req) begin
      if (idle_any) begin
        state_d[idle_tid] = TH_ACTIVE;
        pend_d[idle_tid]  = 1'b1;
        pc_d[idle_tid]    = th_ctl_tspawn_pc_i;
        ack_d             = 1'b1;
        spawn_tid_d       = idle_tid;
      end else begin
        fail_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int t = 0; t < N; t++) begin
        state_q[t] <= (t == 0) ? TH_ACTIVE : TH_IDLE;
        pc_q[t]    <= (t == 0) ? RESET_PC_P : '0;
      end
      pend_q      <= N'(1);
      rr_q        <= '0;
      ack_q       <= 1'b0;
      fail_q      <= 1'b0;
      spawn_tid_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      rr_q        <= rr_d;
      ack_q       <= ack_d;
      fail_q      <= fail_d;
      spawn_tid_q <= spawn_tid_d;
    end
  end

  assign th_ctl_spawn_ack_o  = ack_q;
  assign th_ctl_spawn_fail_o = fail_q;
  assign th_ctl_spawn_tid_o  = spawn_tid_q;
  assign fetch_vld_o         = gnt_vld;
  assign fetch_tid_o         = gnt_tid;
  assign fetch_redirect_o    = pend_q[gnt_tid];
  assign fetch_pc_o          = pc_q[gnt_tid];
  assign halted_o            = ~|active_mask_o;

`ifdef MRV1_TH_SCHED_STATS_EN
  logic [31:0] spawn_cnt_q, fail_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      spawn_cnt_q <= '0;
      fail_cnt_q  <= '0;
    end else begin
      if (ack_q && spawn_cnt_q != '1) spawn_cnt_q <= spawn_cnt_q + 32'd1;
      if (fail_q && fail_cnt_q != '1) fail_cnt_q  <= fail_cnt_q + 32'd1;
    end
  end

  assign stat_spawn_cnt_o = spawn_cnt_q;
  assign stat_fail_cnt_o  = fail_cnt_q;
`endif

endmodule
